// File: rtl/smpl_iter_pkg.sv
// Shared types and helpers for the sample-iteration controller.
package smpl_iter_pkg;

  localparam int SMPL_SIGFIG = 24;

  typedef enum logic {
    WAIT = 1'b0,
    TEST = 1'b1
  } state_e;

  // One extra bit on position arithmetic so x+step cannot wrap at the screen edge.
  function automatic int step_w(input int sigfig);
    return sigfig + 1;
  endfunction

  localparam int SMPL_STEP_W = step_w(SMPL_SIGFIG);

  // Lowest set bit wins; an empty mode falls back to the coarsest step.
  function automatic logic [1:0] ss_w_lg2(input logic [3:0] ss);
    if (ss[0])      return 2'd3;
    else if (ss[1]) return 2'd2;
    else if (ss[2]) return 2'd1;
    else            return 2'd0;
  endfunction

endpackage

// File: rtl/smpl_iter_step.sv
// Next raster-order sample position inside a bounding box, plus row-wrap and last flags.
module smpl_iter_step
  import smpl_iter_pkg::*;
#(
  parameter int SIGFIG = SMPL_SIGFIG
) (
  input  logic [SIGFIG-1:0]         x_i,
  input  logic [SIGFIG-1:0]         y_i,
  input  logic [SIGFIG-1:0]         llx_i,
  input  logic [SIGFIG-1:0]         urx_i,
  input  logic [SIGFIG-1:0]         ury_i,
  input  logic [step_w(SIGFIG)-1:0] step_i,
  output logic [SIGFIG-1:0]         nx_o,
  output logic [SIGFIG-1:0]         ny_o,
  output logic                      wrap_o,
  output logic                      last_o
);

  localparam int SW = step_w(SIGFIG);

  logic signed [SW-1:0] x_w, y_w, urx_w, ury_w, step_w_s, x_sum, y_sum;

  always_comb begin
    x_w      = {x_i[SIGFIG-1], x_i};
    y_w      = {y_i[SIGFIG-1], y_i};
    urx_w    = {urx_i[SIGFIG-1], urx_i};
    ury_w    = {ury_i[SIGFIG-1], ury_i};
    step_w_s = step_i;
    x_sum    = x_w + step_w_s;
    y_sum    = y_w + step_w_s;
    wrap_o   = x_sum > urx_w;
    last_o   = wrap_o && (y_sum > ury_w);
    // On the last sample the result is unused: the controller leaves the triangle.
    nx_o     = wrap_o ? llx_i : x_sum[SIGFIG-1:0];
    ny_o     = wrap_o ? y_sum[SIGFIG-1:0] : y_i;
  end

endmodule

// File: rtl/smpl_iter_ctrl.sv
// Sample-iteration controller: walks a triangle's bounding box one subsample per cycle.
module smpl_iter_ctrl
  import smpl_iter_pkg::*;
#(
  parameter int SIGFIG = SMPL_SIGFIG,
  parameter int RADIX  = 10,
  parameter int VERTS  = 3,
  parameter int AXIS   = 3,
  parameter int COLORS = 3
) (
  input  logic                                   clk,
  input  logic                                   rst,
  input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R13S,
  input  logic [COLORS-1:0][SIGFIG-1:0]          color_R13U,
  input  logic [1:0][1:0][SIGFIG-1:0]            box_R13S,
  input  logic                                   validTri_R13H,
  input  logic [3:0]                             subSample_RnnnnU,
  input  logic                                   halt_RnnnnL,
  output logic                                   halt_R13L,
  output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_R14S,
  output logic [COLORS-1:0][SIGFIG-1:0]          color_R14U,
  output logic [1:0][SIGFIG-1:0]                 sample_R14S,
  output logic                                   validSamp_R14H,
  output logic                                   triDone_R14H,
  output logic [31:0]                            sampCnt_R14U,
  output state_e                                 dbg_state_o
);

  localparam int SW = step_w(SIGFIG);

  // Handshakes: a triangle transfers on a cycle where validTri_R13H & halt_R13L;
  // a sample transfers on a cycle where validSamp_R14H & halt_RnnnnL.
  state_e state_q, state_d;

  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
  logic [COLORS-1:0][SIGFIG-1:0]          color_q;
  logic [SIGFIG-1:0] x_q, y_q, llx_q, urx_q, ury_q, nx, ny;
  logic [SW-1:0]     step_q, step_d;
  logic [31:0]       cnt_q;
  logic              accept, advance, wrap, last;

  smpl_iter_step #(.SIGFIG(SIGFIG)) u_step (
    .x_i    (x_q),
    .y_i    (y_q),
    .llx_i  (llx_q),
    .urx_i  (urx_q),
    .ury_i  (ury_q),
    .step_i (step_q),
    .nx_o   (nx),
    .ny_o   (ny),
    .wrap_o (wrap),
    .last_o (last)
  );

  assign accept  = validTri_R13H && halt_R13L;
  assign advance = (state_q == TEST) && halt_RnnnnL;
  assign step_d  = SW'(1) << (RADIX - int'(ss_w_lg2(subSample_RnnnnU)));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= WAIT;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (accept)               state_d = TEST;
    else if (advance && last) state_d = WAIT;
  end

  always_comb begin
    validSamp_R14H = (state_q == TEST);
    triDone_R14H   = validSamp_R14H && last;
    halt_R13L      = (state_q == WAIT) || (triDone_R14H && halt_RnnnnL);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tri_q   <= '0;
      color_q <= '0;
      x_q     <= '0;
      y_q     <= '0;
      llx_q   <= '0;
      urx_q   <= '0;
      ury_q   <= '0;
      step_q  <= '0;
      cnt_q   <= '0;
    end else if (accept) begin
      tri_q   <= tri_R13S;
      color_q <= color_R13U;
      x_q     <= box_R13S[0][0];
      y_q     <= box_R13S[0][1];
      llx_q   <= box_R13S[0][0];
      urx_q   <= box_R13S[1][0];
      ury_q   <= box_R13S[1][1];
      step_q  <= step_d;
      cnt_q   <= 32'd1;
    end else if (advance && !last) begin
      x_q     <= nx;
      y_q     <= ny;
      cnt_q   <= cnt_q + 32'd1;
    end
  end

  assign tri_R14S       = tri_q;
  assign color_R14U     = color_q;
  assign sample_R14S[0] = x_q;
  assign sample_R14S[1] = y_q;
  assign sampCnt_R14U   = cnt_q;
  assign dbg_state_o    = state_q;

endmodule
